load_store_unit: RTL
====================

# load_store_unit

MEM-stage load/store unit, directly downstream of the EX-stage ALU. It takes the ALU result as the effective address, plus rs2 store data and the funct3 width code. It runs one word-wide, ready-handshaked data-memory transaction, with byte strobes for stores and sign/zero extension for loads. It stalls the pipeline while a transaction is outstanding and returns formatted load data for the WB mux (WBSel = 2'b00 path).

## Interface
Parameters:
- TIMEOUT, 16: max cycles in BUSY waiting for mem_ready before the access is aborted as a fault (≥1).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  EX/MEM register holds a live instruction.
- mem_read  in  1  instruction is a load.
- mem_write  in  1  instruction is a store.
- funct3  in  3  access width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  in  32  effective address (ALU result).
- store_data  in  32  rs2 value, forwarded.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  1 = write, registered.
- mem_addr  out  32  {addr[31:2],2'b00}, registered.
- mem_wdata  out  32  lane-replicated store data, registered.
- mem_wstrb  out  4  byte enables (0000 on reads), registered.
- mem_ready  in  1  memory completes the transaction this cycle.
- mem_rdata  in  32  read word, valid with mem_ready.
- stall  out  1  freeze PC/IF/ID/EX/EX-MEM; combinational.
- load_data  out  32  extended load result, registered; holds until the next load completes.
- load_valid  out  1  one-cycle pulse with new load_data.
- fault  out  1  one-cycle pulse: misaligned, illegal funct3, read+write both set, or timeout.

## Operation
- A memory op is in_valid & (mem_read | mem_write).
- States: IDLE, BUSY, DONE.
- IDLE, no memory op: stall=0, nothing issued.
- IDLE, illegal op: no request; fault pulses next cycle; stall=0; back in IDLE. Illegal means any of:
  - mem_read & mem_write both set.
  - funct3 ∉ {000,001,010,100,101} for loads, or ∉ {000,001,010} for stores.
  - halfword with addr[0]=1.
  - word with addr[1:0]≠00.
- IDLE, legal op: stall=1; latch request fields; → BUSY with mem_req=1 next cycle. Counter is cleared.
- Store formatting by width:
  - SB: wdata = {4{sd[7:0]}}, wstrb = 0001<<addr[1:0].
  - SH: wdata = {2{sd[15:0]}}, wstrb = addr[1] ? 1100 : 0011.
  - SW: wdata = sd, wstrb = 1111.
- BUSY: stall=1; mem_req and the request fields are held stable.
  - mem_ready=1 → capture/extend rdata (loads), → DONE, mem_req=0 next cycle.
  - Otherwise counter++. When the counter reaches TIMEOUT-1 without ready → DONE with fault (no load_valid, load_data unchanged).
- Load extension: select the byte lane by addr[1:0] or the half by addr[1]. LB/LH sign-extend; LBU/LHU zero-extend.
- DONE: stall=0, so the held instruction advances this cycle.
  - in_valid is ignored (it is the same instruction).
  - load_valid pulses for loads; fault pulses on timeout.
  - → IDLE.
- A mem_ready seen while in IDLE or DONE is ignored.

## Timing
- Reset: state=IDLE; mem_req, mem_we=0; mem_addr, mem_wdata, load_data=0; mem_wstrb=0000; load_valid, fault=0; counter=0. stall=0 while in IDLE after reset.
- rst asserted mid-transaction: IDLE at the next edge; mem_req drops the same edge; no load_valid or fault pulse.
- Op accepted in cycle N:
  - mem_req=1 from N+1.
  - mem_ready first sampled high in cycle M≥N+1 → DONE in M+1.
  - stall is high N..M.
  - load_data/load_valid are valid in M+1.
  - Best case: 2 stall cycles.
- Timeout: mem_req high for exactly TIMEOUT cycles, then DONE with fault.
- Back-to-back memory ops: the second is accepted in the cycle after DONE, not in DONE.

## Test plan
- LW at addr 0x100; memory returns 0xDEADBEEF with ready at N+1 → mem_addr=0x100, wstrb=0000, stall high 2 cycles, load_data=0xDEADBEEF, load_valid 1 cycle.
- LB at 0x103 and LBU at 0x103, rdata=0x80FF_1234 → load_data=0xFFFFFF80 and 0x00000080.
- LH/LHU at 0x102, rdata=0x8001_0000 → 0xFFFF8001 / 0x00008001.
- SB at 0x101 with sd=0x000000AB → mem_we=1, wdata=0xABABABAB, wstrb=0010.
- SH at 0x102 with sd=0x1234 → wstrb=1100, wdata=0x12341234.
- SW at 0x102 → fault pulse, mem_req never asserted, stall=0.
- mem_ready held low, TIMEOUT=4 → mem_req high 4 cycles, then fault pulse, stall drops, load_data unchanged.
- rst asserted in the 2nd BUSY cycle → IDLE next edge, mem_req=0, no pulses.
- Back-to-back LW, LW → second mem_req starts the cycle after the first DONE; both load_valid pulses are seen.

Source files
------------

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: issues one ready-handshaked word access per memory op,
// formats store lanes/strobes, extends load data and stalls the pipeline meanwhile.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        fault
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_wstrb_q, mem_wstrb_d;
    logic [XLEN-1:0]   load_data_q, load_data_d;
    logic              load_valid_q, load_valid_d;
    logic              fault_q, fault_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        off_q, off_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              mem_op_c;
    logic              illegal_c;
    logic              timeout_c;
    logic              stall_c;
    logic [XLEN-1:0]   st_wdata_c;
    logic [3:0]        st_wstrb_c;

    // Lane select by address offset, then sign/zero extension by funct3.
    function automatic logic [XLEN-1:0] extend_load(input logic [2:0]      f3,
                                                     input logic [1:0]      off,
                                                     input logic [XLEN-1:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  extend_load = {{24{b[7]}}, b};
            3'b001:  extend_load = {{16{h[15]}}, h};
            3'b100:  extend_load = {24'h0, b};
            3'b101:  extend_load = {16'h0, h};
            default: extend_load = word;
        endcase
    endfunction

    always_comb begin
        logic legal_ld, legal_st, misaligned;
        mem_op_c   = in_valid & (mem_read | mem_write);
        legal_ld   = (funct3 == 3'b000) | (funct3 == 3'b001) | (funct3 == 3'b010) |
                     (funct3 == 3'b100) | (funct3 == 3'b101);
        legal_st   = (funct3 == 3'b000) | (funct3 == 3'b001) | (funct3 == 3'b010);
        misaligned = ((funct3[1:0] == 2'b01) & addr[0]) |
                     ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
        illegal_c  = (mem_read & mem_write) | (mem_read & ~legal_ld) |
                     (mem_write & ~legal_st) | misaligned;
    end

    // Store lane replication and byte strobes.
    always_comb begin
        st_wdata_c = store_data;
        st_wstrb_c = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                st_wdata_c = {4{store_data[7:0]}};
                st_wstrb_c = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                st_wdata_c = {2{store_data[15:0]}};
                st_wstrb_c = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata_c = store_data;
                st_wstrb_c = 4'b1111;
            end
        endcase
    end

    assign timeout_c = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mem_op_c && !illegal_c) state_d = BUSY;
            BUSY:    if (mem_ready || timeout_c) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_c      = 1'b0;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        fault_d      = 1'b0;
        funct3_d     = funct3_q;
        off_d        = off_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                if (mem_op_c) begin
                    if (illegal_c) begin
                        fault_d = 1'b1;
                    end else begin
                        stall_c     = 1'b1;
                        mem_req_d   = 1'b1;
                        mem_we_d    = mem_write;
                        mem_addr_d  = {addr[31:2], 2'b00};
                        mem_wdata_d = mem_write ? st_wdata_c : mem_wdata_q;
                        mem_wstrb_d = mem_write ? st_wstrb_c : 4'b0000;
                        funct3_d    = funct3;
                        off_d       = addr[1:0];
                        cnt_d       = '0;
                    end
                end
            end
            BUSY: begin
                stall_c = 1'b1;
                if (mem_ready || timeout_c) begin
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_wstrb_d = 4'b0000;
                    if (mem_ready) begin
                        if (!mem_we_q) begin
                            load_data_d  = extend_load(funct3_q, off_q, mem_rdata);
                            load_valid_d = 1'b1;
                        end
                    end else begin
                        fault_d = 1'b1;
                    end
                end else begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= 4'b0000;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            funct3_q     <= 3'b000;
            off_q        <= 2'b00;
            cnt_q        <= '0;
        end else begin
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            fault_q      <= fault_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            cnt_q        <= cnt_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign stall      = stall_c;
    assign load_data  = load_data_q;
    assign load_valid = load_valid_q;
    assign fault      = fault_q;

endmodule
